// File: rtl/data_break_arbiter.sv
// rtl/data_break_arbiter.sv - Shares the CPU data-break (DMA) path among NCHAN requesters
// Build option: DB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module data_break_arbiter #(
  parameter int NCHAN   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCHAN-1:0]    req,
  input  logic [NCHAN-1:0]    dir,
  input  logic [15*NCHAN-1:0] addr,
  input  logic [12*NCHAN-1:0] wdata,
  input  logic                break_in_prog,
  input  logic [11:0]         mem_rdata,
  output logic                data_break,
  output logic                to_disk,
  output logic [14:0]         db_addr,
  output logic [11:0]         db_wdata,
  output logic [NCHAN-1:0]    ack,
  output logic [11:0]         rdata,
  output logic [NCHAN-1:0]    grant,
  output logic                stall
);

  localparam int            IW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int            CW   = (TIMEOUT > 4095) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DONE} state_t;

  state_t        state, next_state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW:0]   scan;
  logic [CW-1:0] wait_cnt;

  // Find the first pending channel at or after the priority pointer
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NCHAN)) scan = scan - (IW+1)'(NCHAN);
      if (req[scan[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan[IW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    next_state = state;
    data_break = 1'b0;
    ack        = '0;
    case (state)
      IDLE:   if (pick_valid && !break_in_prog) next_state = REQ;
      REQ: begin
        data_break = 1'b1;
        if (break_in_prog) next_state = ACTIVE;
      end
      ACTIVE: if (!break_in_prog) next_state = DONE;
      DONE: begin
        ack        = grant;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the winner's grant, direction, address and data for the whole break
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= '0;
      to_disk  <= 1'b0;
      db_addr  <= '0;
      db_wdata <= '0;
    end else if (state == IDLE && next_state == REQ) begin
      grant    <= NCHAN'(1) << pick_idx;
      to_disk  <= dir[pick_idx];
      db_addr  <= addr[15*pick_idx +: 15];
      db_wdata <= wdata[12*pick_idx +: 12];
    end else if (state == DONE) begin
      grant    <= '0;
    end
  end

  // Track memory data while a read break is in progress; the last value is DB2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                           rdata <= '0;
    else if (state == ACTIVE && break_in_prog && to_disk)   rdata <= mem_rdata;
  end

  // Count cycles waiting in REQ; stall is sticky until the next completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      stall    <= 1'b0;
    end else if (state == REQ && next_state == REQ) begin
      if (wait_cnt != TMO)        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == TMO - 1'b1) stall    <= 1'b1;
    end else begin
      wait_cnt <= '0;
      if (next_state == DONE) stall <= 1'b0;
    end
  end

`ifdef DB_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at channel 0
  assign ptr = '0;
`else
  logic [IW-1:0] winner;

  // Remember the winner and rotate the pointer just past it on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= '0;
      winner <= '0;
    end else begin
      if (state == IDLE && next_state == REQ) winner <= pick_idx;
      if (state == DONE) ptr <= (winner == IW'(NCHAN - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_break_arbiter.sv
// tb/tb_data_break_arbiter.sv - Directed and randomized self-checking bench for data_break_arbiter
module tb_data_break_arbiter;

  localparam int NCHAN   = 4;
  localparam int TIMEOUT = 20;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NCHAN-1:0]    req = '0;
  logic [NCHAN-1:0]    dir = '0;
  logic [15*NCHAN-1:0] addr = '0;
  logic [12*NCHAN-1:0] wdata = '0;
  logic                break_in_prog = 1'b0;
  logic [11:0]         mem_rdata = '0;
  logic                data_break;
  logic                to_disk;
  logic [14:0]         db_addr;
  logic [11:0]         db_wdata;
  logic [NCHAN-1:0]    ack;
  logic [11:0]         rdata;
  logic [NCHAN-1:0]    grant;
  logic                stall;

  int          checks = 0;
  int          errors = 0;
  int          rr_ptr = 0;
  logic [11:0] exp_rdata = '0;

  data_break_arbiter #(.NCHAN(NCHAN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dir(dir), .addr(addr), .wdata(wdata),
    .break_in_prog(break_in_prog), .mem_rdata(mem_rdata), .data_break(data_break),
    .to_disk(to_disk), .db_addr(db_addr), .db_wdata(db_wdata), .ack(ack),
    .rdata(rdata), .grant(grant), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_data_break"}, data_break, 0);
    chk({pfx, "_to_disk"},    to_disk,    0);
    chk({pfx, "_db_addr"},    db_addr,    0);
    chk({pfx, "_db_wdata"},   db_wdata,   0);
    chk({pfx, "_ack"},        ack,        0);
    chk({pfx, "_rdata"},      rdata,      0);
    chk({pfx, "_grant"},      grant,      0);
    chk({pfx, "_stall"},      stall,      0);
  endtask

  // Reference arbitration: first requester found walking upward from the pointer
  function automatic int pick(input logic [NCHAN-1:0] r, input int p);
    for (int k = 0; k < NCHAN; k++)
      if (r[(p + k) % NCHAN]) return (p + k) % NCHAN;
    return -1;
  endfunction

  // One complete break acting as the CPU; starts and ends in IDLE just after an edge
  task automatic do_break(input int delay, input bit drop_early, input bit fix_mem,
                          input logic [11:0] fix_val, output int obs_w);
    int          w;
    logic [14:0] ea;
    logic [11:0] ew;
    logic        ed;
    logic [11:0] m;
    obs_w = -1;
    m     = '0;
    w = pick(req, rr_ptr);
    checks++;
    assert (w >= 0) else begin
      errors++;
      $error("FAIL pick: observed no pending request expected one");
    end
    if (w < 0) return;
    ea = addr[15*w +: 15];
    ew = wdata[12*w +: 12];
    ed = dir[w];
    tick;
    for (int k = 0; k < NCHAN; k++) if (grant[k]) obs_w = k;
    chk("grant", grant, 1 << w);
    chk("data_break_req", data_break, 1);
    chk("db_addr", db_addr, ea);
    chk("db_wdata", db_wdata, ew);
    chk("to_disk", to_disk, ed);
    chk("stall_start", stall, 0);
    for (int j = 1; j <= delay; j++) begin
      tick;
      chk("data_break_hold", data_break, 1);
      chk("db_addr_hold", db_addr, ea);
      chk("stall_wait", stall, (j >= TIMEOUT));
    end
    if (drop_early) req[w] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      break_in_prog = 1'b1;
      m = fix_mem ? fix_val : 12'($urandom);
      mem_rdata = m;
      tick;
      chk("data_break_active", data_break, 0);
      chk("db_addr_active", db_addr, ea);
      chk("ack_active", ack, 0);
      chk("stall_held", stall, (delay >= TIMEOUT));
    end
    if (ed) exp_rdata = m;
    break_in_prog = 1'b0;
    mem_rdata = 12'($urandom);
    tick;
    chk("ack", ack, 1 << w);
    chk("rdata", rdata, exp_rdata);
    chk("stall_done", stall, 0);
    chk("db_wdata_done", db_wdata, ew);
    chk("to_disk_done", to_disk, ed);
`ifndef DB_FIXED_PRIORITY_EN
    rr_ptr = (w + 1) % NCHAN;
`endif
    req[w] = 1'b0;
    tick;
    chk("ack_once", ack, 0);
    chk("grant_clear", grant, 0);
    chk("data_break_idle", data_break, 0);
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick;

    // Contention: all channels request continuously
    dir = '0;
    for (int i = 0; i < 5; i++) begin
      req = '1;
      do_break(i % 2, 1'b0, 1'b0, 12'd0, w);
`ifdef DB_FIXED_PRIORITY_EN
      chk("order_fixed", w, 0);
`else
      chk("order_rr", w, i % NCHAN);
`endif
    end
    req = '0;
    tick;

    // Single write from channel 0
    addr[0 +: 15]  = 15'o01234;
    wdata[0 +: 12] = 12'o7070;
    dir[0] = 1'b0;
    req[0] = 1'b1;
    do_break(0, 1'b0, 1'b0, 12'd0, w);
    chk("write_winner", w, 0);

    // Single read from channel 1
    addr[15 +: 15] = 15'o00777;
    dir[1] = 1'b1;
    req[1] = 1'b1;
    do_break(1, 1'b0, 1'b1, 12'o4321, w);
    chk("read_rdata_held", rdata, 12'o4321);

    // Channel 2 withdraws its request while waiting in REQ
    req = 4'b0100;
    do_break(2, 1'b1, 1'b0, 12'd0, w);
    tick;
    chk("withdraw_no_rearb", data_break, 0);
    chk("withdraw_no_ack", ack, 0);

    // Stall: CPU withholds the break past TIMEOUT
    req = 4'b1000;
    do_break(TIMEOUT + 5, 1'b0, 1'b0, 12'd0, w);

    // Foreign break already running: arbitration must wait
    break_in_prog = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("foreign_wait_db", data_break, 0);
      chk("foreign_wait_grant", grant, 0);
    end
    break_in_prog = 1'b0;
    do_break(0, 1'b0, 1'b0, 12'd0, w);

    // Reset in the middle of an active read break
    req = 4'b0010;
    dir[1] = 1'b1;
    tick;
    break_in_prog = 1'b1;
    mem_rdata = 12'o1111;
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    chk("midreset_no_ack", ack, 0);
    reset_n = 1'b1;
    rr_ptr = 0;
    exp_rdata = '0;
    tick;
    chk("post_reset_wait", data_break, 0);
    break_in_prog = 1'b0;
    do_break(0, 1'b0, 1'b0, 12'd0, w);
    chk("post_reset_winner", w, 1);

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      req = req | NCHAN'($urandom);
      if (req == '0) req[$urandom_range(NCHAN - 1, 0)] = 1'b1;
      dir = NCHAN'($urandom);
      for (int k = 0; k < NCHAN; k++) begin
        addr[15*k +: 15]  = 15'($urandom);
        wdata[12*k +: 12] = 12'($urandom);
      end
      do_break($urandom_range(3, 0), ($urandom_range(3, 0) == 0), 1'b0, 12'd0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
